// File: rtl/mdio_master_ctrl.sv
// MDIO (Clause 22) management master: accepts one read/write request at a time,
// serialises the frame on MDC/MDIO and returns a one-cycle completion pulse.
module mdio_master_ctrl #(
    parameter int CLK_DIV     = 25,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdio_mdc_mdc,
    input  logic        mdio_mdc_mdio_i,
    output logic        mdio_mdc_mdio_o,
    output logic        mdio_mdc_mdio_t
);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, GAP} state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV);

    state_t      state, state_next;
    logic [8:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic        lat_write;
    logic [4:0]  lat_phy, lat_reg;
    logic [15:0] lat_wdata;

    logic        in_frame, half_end, rise, bit_end, last_bit, accept;
    logic [5:0]  bit_len;
    logic [3:0]  next_idx;
    logic [15:0] hdr;
    logic        drv_o, drv_t;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        drv_o      = 1'b1;
        drv_t      = 1'b1;
        bit_len    = 6'd1;
        in_frame   = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);
        half_end   = (div_cnt == HALF_LAST);
        rise       = in_frame && !mdio_mdc_mdc && half_end;
        bit_end    = in_frame && mdio_mdc_mdc && half_end;
        accept     = (state == IDLE) && req_valid;
        hdr        = {2'b01, (lat_write ? 2'b01 : 2'b10), lat_phy, lat_reg, 2'b00};

        case (state)
            PRE:     bit_len = 6'd32;
            HDR:     bit_len = 6'd14;
            TA:      bit_len = 6'd2;
            DATA:    bit_len = 6'd16;
            default: bit_len = 6'd1;
        endcase
        last_bit = (bit_cnt == bit_len - 6'd1);

        case (state)
            IDLE: if (req_valid) state_next = PREAMBLE_EN ? PRE : HDR;
            PRE:  if (bit_end && last_bit) state_next = HDR;
            HDR:  if (bit_end && last_bit) state_next = TA;
            TA:   if (bit_end && last_bit) state_next = DATA;
            DATA: if (bit_end && last_bit) state_next = GAP;
            GAP:  if (div_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Value to present for the bit that starts on the next low phase.
        next_idx = (state_next != state) ? 4'd0 : bit_cnt[3:0] + 4'd1;
        case (state_next)
            PRE: begin
                drv_o = 1'b1;
                drv_t = 1'b0;
            end
            HDR: begin
                drv_o = hdr[4'd15 - next_idx];
                drv_t = 1'b0;
            end
            TA: if (lat_write) begin
                drv_o = (next_idx == 4'd0);
                drv_t = 1'b0;
            end
            DATA: if (lat_write) begin
                drv_o = lat_wdata[4'd15 - next_idx];
                drv_t = 1'b0;
            end
            default: ;
        endcase

        req_ready = (state == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt         <= '0;
            bit_cnt         <= '0;
            lat_write       <= 1'b0;
            lat_phy         <= '0;
            lat_reg         <= '0;
            lat_wdata       <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            mdio_mdc_mdc    <= 1'b0;
            mdio_mdc_mdio_o <= 1'b1;
            mdio_mdc_mdio_t <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                lat_write       <= req_write;
                lat_phy         <= req_phy;
                lat_reg         <= req_reg;
                lat_wdata       <= req_wdata;
                rsp_rdata       <= '0;
                rsp_err         <= 1'b0;
                div_cnt         <= '0;
                bit_cnt         <= '0;
                mdio_mdc_mdc    <= 1'b0;
                mdio_mdc_mdio_o <= drv_o;
                mdio_mdc_mdio_t <= drv_t;
            end else if (in_frame) begin
                if (half_end) begin
                    div_cnt      <= '0;
                    mdio_mdc_mdc <= !mdio_mdc_mdc;
                end else begin
                    div_cnt <= div_cnt + 9'd1;
                end
                if (rise && !lat_write) begin
                    if (state == TA && bit_cnt == 6'd1) rsp_err <= mdio_mdc_mdio_i;
                    if (state == DATA) rsp_rdata <= {rsp_rdata[14:0], mdio_mdc_mdio_i};
                end
                if (bit_end) begin
                    mdio_mdc_mdio_o <= drv_o;
                    mdio_mdc_mdio_t <= drv_t;
                    bit_cnt         <= (state_next != state) ? 6'd0 : bit_cnt + 6'd1;
                    if (state_next == GAP) rsp_valid <= 1'b1;
                end
            end else if (state == GAP) begin
                div_cnt <= (div_cnt == GAP_LAST) ? 9'd0 : div_cnt + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Directed bench for mdio_master_ctrl: a vector table of frames against a small
// PHY model, plus back-to-back, mid-frame reset and no-preamble sequences.
module tb_mdio_master_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_valid2 = 1'b0;
    logic        req_write = 1'b0;
    logic [4:0]  req_phy = '0, req_reg = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mdc, mdio_o, mdio_t;
    logic [15:0] rsp_rdata;
    logic        mdio_i = 1'b1;
    logic        req_ready2, rsp_valid2, rsp_err2, mdc2, mdio_o2, mdio_t2;
    logic [15:0] rsp_rdata2;
    logic        mdio_i2 = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdio_master_ctrl #(.CLK_DIV(2), .PREAMBLE_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mdio_mdc_mdc(mdc), .mdio_mdc_mdio_i(mdio_i),
        .mdio_mdc_mdio_o(mdio_o), .mdio_mdc_mdio_t(mdio_t)
    );

    mdio_master_ctrl #(.CLK_DIV(1), .PREAMBLE_EN(1'b0)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .mdio_mdc_mdc(mdc2), .mdio_mdc_mdio_i(mdio_i2),
        .mdio_mdc_mdio_o(mdio_o2), .mdio_mdc_mdio_t(mdio_t2)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wdata;
        logic        present;
        logic [15:0] pdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    // PHY model and bit capture: bit n occupies frame position 63-n.
    logic        phy_present = 1'b0;
    logic [15:0] phy_data = '0;
    int          bitn = 0;
    logic        mdc_q = 1'b0;
    logic [63:0] cap_o = '0, cap_t = '0;

    function automatic logic phy_bit(input int n, input logic present, input logic [15:0] d);
        if (!present)           return 1'b1;
        if (n == 47)            return 1'b0;
        if (n >= 48 && n <= 63) return d[15 - (n - 48)];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (req_ready) begin
            bitn   = 0;
            mdio_i = 1'b1;
        end else if (mdc && !mdc_q) begin
            if (bitn < 64) begin
                cap_o[63 - bitn] = mdio_o;
                cap_t[63 - bitn] = mdio_t;
            end
            bitn++;
            mdio_i = phy_bit(bitn, phy_present, phy_data);
        end
        mdc_q = mdc;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input vec_t v);
        return {32'hFFFF_FFFF, 2'b01, (v.wr ? 2'b01 : 2'b10), v.phy, v.rg,
                (v.wr ? 2'b10 : 2'b11), (v.wr ? v.wdata : 16'hFFFF)};
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (!req_ready && k < 1000) begin
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic drive_fields(input vec_t v);
        req_write   = v.wr;
        req_phy     = v.phy;
        req_reg     = v.rg;
        req_wdata   = v.wdata;
        phy_present = v.present;
        phy_data    = v.pdata;
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        logic [63:0] et;
        et = v.wr ? 64'h0 : 64'h3FFFF;
        check({tag, "_mdio_t"}, cap_t, et);
        check({tag, "_mdio_o"}, cap_o | et, exp_frame(v) | et);
    endtask

    task automatic do_txn(input string tag, input vec_t v);
        int n = 0;
        wait_idle();
        drive_fields(v);
        req_valid = 1'b1;
        do begin
            @(posedge clk); #1; n++;
            req_valid = 1'b0;
        end while (!rsp_valid && n < 1000);
        check({tag, "_latency"}, 64'(n), 64'd257);
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        check({tag, "_err"}, 64'(rsp_err), 64'(v.exp_err));
        check_frame(tag, v);
    endtask

    initial begin
        vec_t a, b;
        int n, m, pulses, rises;
        logic gap_ok, prev;
        logic [31:0] f2;

        vecs[0] = '{1'b1, 5'h07, 5'h00, 16'h1140, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h796D, 16'h796D, 1'b0};
        vecs[2] = '{1'b0, 5'h05, 5'h03, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 5'h1F, 5'h1F, 16'hA5A5, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 5'h10, 5'h1E, 16'h0000, 1'b1, 16'h8001, 16'h8001, 1'b0};

        // Asynchronous reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset_outputs",
              64'({req_ready, rsp_valid, rsp_err, mdc, mdio_t, mdio_o, rsp_rdata}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000}));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) check("vec0_frame_hand", cap_o, 64'hFFFF_FFFF_5382_1140);
        end

        // Request held high across two writes; fields change while busy.
        a = vecs[0];
        b = '{1'b1, 5'h0A, 5'h11, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 1'b0};
        wait_idle();
        drive_fields(a);
        req_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 1) drive_fields(b);
        end while (!rsp_valid && n < 1000);
        check("b2b_first_latency", 64'(n), 64'd257);
        check_frame("b2b_first", a);
        m = 0;
        gap_ok = 1'b1;
        do begin
            @(posedge clk); #1; m++;
            if (!req_ready && (mdc || !mdio_t)) gap_ok = 1'b0;
        end while (!req_ready && m < 50);
        check("b2b_gap_len", 64'(m), 64'd5);
        check("b2b_gap_lines", 64'(gap_ok), 64'd1);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            req_valid = 1'b0;
        end while (!rsp_valid && n < 1000);
        check("b2b_second_latency", 64'(n), 64'd257);
        check_frame("b2b_second", b);

        // Reset during DATA bit 5 of a read.
        wait_idle();
        drive_fields(vecs[1]);
        req_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            req_valid = 1'b0;
        end while (n < 214 && !rsp_valid);
        check("midreset_partial_rdata", 64'(rsp_rdata), 64'h000F);
        #2 reset = 1'b1;
        #1;
        check("midreset_outputs",
              64'({req_ready, rsp_valid, rsp_err, mdc, mdio_t, mdio_o, rsp_rdata}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000}));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pulses = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        check("midreset_no_rsp", 64'(pulses), 64'd0);
        do_txn("after_reset", vecs[1]);

        // No preamble, CLK_DIV=1: 32-bit frame.
        req_write = 1'b1;
        req_phy   = 5'h03;
        req_reg   = 5'h04;
        req_wdata = 16'hCAFE;
        req_valid2 = 1'b1;
        n = 0;
        rises = 0;
        f2 = '0;
        prev = mdc2;
        do begin
            @(posedge clk); #1; n++;
            req_valid2 = 1'b0;
            if (mdc2 && !prev) begin
                f2 = {f2[30:0], mdio_o2};
                rises++;
            end
            prev = mdc2;
        end while (!rsp_valid2 && n < 1000);
        check("nopre_latency", 64'(n), 64'd65);
        check("nopre_bits", 64'(rises), 64'd32);
        check("nopre_frame", 64'(f2), 64'h5192_CAFE);
        check("nopre_rsp", 64'({rsp_err2, rsp_rdata2}), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdio_master_ctrl.md
MDIO_MASTER_CTRL -- requirements
Module: mdio_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, clk cycles per MDC half-period; legal range 1..255.
REQ-002 SHALL have parameter PREAMBLE_EN, default 1; 1 sends a 32-bit preamble, 0 suppresses it.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit, transaction request.
REQ-006 SHALL have port req_ready, output, 1 bit, controller can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit, 1 = write, 0 = read.
REQ-008 SHALL have port req_phy, input, 5 bits, PHY address.
REQ-009 SHALL have port req_reg, input, 5 bits, register address.
REQ-010 SHALL have port req_wdata, input, 16 bits, write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit, one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 16 bits, read data (0x0000 for writes).
REQ-013 SHALL have port rsp_err, output, 1 bit, read saw no PHY turnaround.
REQ-014 SHALL have port mdio_mdc_mdc, output, 1 bit, management clock.
REQ-015 SHALL have port mdio_mdc_mdio_i, input, 1 bit, MDIO from the IOBUF.
REQ-016 SHALL have port mdio_mdc_mdio_o, output, 1 bit, MDIO drive value.
REQ-017 SHALL have port mdio_mdc_mdio_t, output, 1 bit, tristate: 1 = released, 0 = driven.

Function
REQ-018 SHALL implement the states IDLE, PRE, HDR, TA, DATA and GAP.
REQ-019 SHALL assert req_ready only in IDLE and SHALL accept a request on a clk with req_valid && req_ready, latching all req_* fields.
REQ-020 SHALL go from IDLE to PRE on acceptance, or to HDR when PREAMBLE_EN=0.
REQ-021 SHALL form each MDIO bit as one MDC period: low for CLK_DIV clks, then high for CLK_DIV clks.
REQ-022 SHALL update mdio_o/mdio_t only at the start of an MDC low phase.
REQ-023 SHALL sample mdio_i on the clk that drives MDC from 0 to 1.
REQ-024 SHALL drive 32 bits of 1 in PRE.
REQ-025 SHALL drive 14 bits in HDR, MSB first: ST=01, OP (write 01, read 10), PHYAD[4:0], REGAD[4:0].
REQ-026 SHALL drive TA=10 on a write.
REQ-027 SHALL release mdio_t=1 for both TA bits on a read and SHALL sample the second TA bit; a value of 1 sets rsp_err=1.
REQ-028 SHALL drive req_wdata[15:0] MSB first in DATA on a write.
REQ-029 SHALL keep mdio_t=1 in DATA on a read and shift 16 samples into rsp_rdata, MSB first.
REQ-030 SHALL still capture data when rsp_err=1.
REQ-031 SHALL use a 6-bit bit counter that rolls over between states with no idle bit inserted.
REQ-032 SHALL, after the last DATA high phase ends, pulse rsp_valid for exactly 1 clk.
REQ-033 SHALL present rsp_rdata/rsp_err on that rsp_valid clk and hold them until the next acceptance.
REQ-034 SHALL enter GAP on the rsp_valid clk.
REQ-035 SHALL hold mdio_t=1 and MDC=0 in GAP for 2*CLK_DIV clks, then return to IDLE.
REQ-036 SHALL make the time from acceptance to rsp_valid (64 or 32 bits) * 2*CLK_DIV clks, +1 clk.
REQ-037 SHALL, in IDLE, drive MDC=0, mdio_t=1 and mdio_o=1.
REQ-038 SHALL ignore req_valid outside IDLE; a request held high SHALL be accepted on the first IDLE clk after GAP.
REQ-039 SHALL drop the request fields of a rejected request; no queueing.

Reset
REQ-040 SHALL, on reset asserted, immediately force the state to IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0x0000, rsp_err=0, MDC=0, mdio_t=1 and mdio_o=1.
REQ-041 SHALL apply REQ-040 mid-frame, abort the frame and issue no rsp_valid.
REQ-042 SHALL zero the divider and bit counters on reset.

Verification
REQ-043 SHALL cover a write with CLK_DIV=2, phy=0x07, reg=0x00, wdata=0x1140, giving 32 ones, then 0101 00111 00000 10 0001000101000000, and rsp_valid 257 clks after acceptance with rdata=0x0000 and err=0.
REQ-044 SHALL cover a read with phy=0x01, reg=0x02 and a PHY model driving TA=Z0 and data 0x796D, giving rsp_rdata=0x796D, rsp_err=0, and mdio_t=1 from the first TA bit to the end.
REQ-045 SHALL cover a read with no PHY (mdio_i stuck at 1), giving rsp_rdata=0xFFFF and rsp_err=1.
REQ-046 SHALL cover req_valid held high for two writes, giving a second acceptance exactly 2*CLK_DIV+1 clks after the first rsp_valid and MDC=0, mdio_t=1 throughout the gap.
REQ-047 SHALL cover reset asserted during DATA bit 5, giving all outputs at REQ-040 values with no clk edge needed, no rsp_valid, and a following read completing correctly.
REQ-048 SHALL cover PREAMBLE_EN=0 with CLK_DIV=1, giving a 32-bit frame and rsp_valid 65 clks after acceptance.
